// File: rtl/ssd_scan_controller_pkg.sv
// ssd_scan_controller_pkg: shared types and constants for the seven-segment scan controller.
package ssd_scan_controller_pkg;
  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [7:0] ANODES_OFF = 8'hFF;
  localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        lz;
  } disp_t;
endpackage

// File: rtl/ssd_hex_decode.sv
// ssd_hex_decode: hex nibble to active-low abcdefg segment pattern (a is bit 6).
module ssd_hex_decode
  import ssd_scan_controller_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[nibble];
endmodule

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: 8-digit multiplexed seven-segment driver with blanking,
// leading-zero suppression and frame-synchronous double-buffered display data.
module ssd_scan_controller
  import ssd_scan_controller_pkg::*;
#(
  parameter int DIGIT_CYCLES = 262144,
  parameter int BLANK_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        lz_suppress,
  input  logic        load,
  output logic [7:0]  anode_n,
  output logic [7:0]  cathode_n,
  output logic        frame_done
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] idx, idx_nx;
  disp_t act, pend, in_d;
  logic pflag, boundary, lit;
  logic [7:0] sup, an_nx, ca_nx;
  logic [6:0] seg;
  assign in_d = {digits_in, dp_in, digit_en, lz_suppress};
  assign boundary = idx == 3'd7 && cnt == LAST;
  assign frame_done = boundary;
  // a digit is a leading zero when it and every more significant nibble are zero
  assign sup[0] = 1'b0;
  for (genvar g = 1; g < 8; g++) begin : g_sup
    assign sup[g] = act.lz && act.digits[31:4*g] == '0;
  end
  ssd_hex_decode u_dec (
    .nibble(act.digits[{idx, 2'b00} +: 4]),
    .seg   (seg)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  always_comb begin
    cnt_nx   = cnt == LAST ? '0 : cnt + 1'b1;
    idx_nx   = cnt == LAST ? idx + 3'd1 : idx;
    state_nx = cnt_nx < BLANK_END ? ST_BLANK : ST_DRIVE;
  end
  always_comb begin
    lit   = state == ST_DRIVE && act.en[idx] && !sup[idx];
    an_nx = lit ? ~(8'd1 << idx) : ANODES_OFF;
    ca_nx = lit ? {seg, ~act.dp[idx]} : {SEG_OFF, 1'b1};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      anode_n   <= ANODES_OFF;
      cathode_n <= 8'hFF;
    end else begin
      anode_n   <= an_nx;
      cathode_n <= ca_nx;
    end
  // a load on the boundary cycle goes straight to the active set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act   <= '0;
      pend  <= '0;
      pflag <= 1'b0;
    end else if (boundary) begin
      if (load || pflag) act <= load ? in_d : pend;
      pflag <= 1'b0;
    end else if (load) begin
      pend  <= in_d;
      pflag <= 1'b1;
    end
endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller: randomized and directed checks against a slot-arithmetic reference model.
module tb_ssd_scan_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0] dp_in = '0, digit_en = '0;
  logic lz_suppress = 1'b0, load = 1'b0;
  logic [7:0] anode_n, cathode_n;
  logic frame_done;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ssd_scan_controller #(.DIGIT_CYCLES(16), .BLANK_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .digit_en(digit_en),
    .lz_suppress(lz_suppress), .load(load), .anode_n(anode_n), .cathode_n(cathode_n),
    .frame_done(frame_done)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  typedef struct {
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        lz;
  } img_t;
  logic [6:0] segtab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  img_t act, pend, cur;
  bit pf;
  int n;
  logic [15:0] exp_out;
  // expected {anode_n, cathode_n} produced during frame cycle c (c = slot*16 + position)
  function automatic logic [15:0] model_out(int c, img_t a);
    int pos, d;
    logic [3:0] nib;
    logic supp;
    pos = c % 16;
    d = (c / 16) % 8;
    if (pos < 4) return 16'hFFFF;
    nib = a.d[4*d +: 4];
    supp = a.lz && d > 0 && (a.d >> (4*d)) == 0;
    if (!a.en[d] || supp) return 16'hFFFF;
    return {~(8'd1 << d), segtab[nib], ~a.dp[d]};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n = 0;
      act = '{0, 0, 0, 0};
      pend = '{0, 0, 0, 0};
      pf = 0;
      exp_out = 16'hFFFF;
    end else begin
      cur = '{digits_in, dp_in, digit_en, lz_suppress};
      exp_out = model_out(n, act);
      if (n == 127) begin
        if (load) act = cur;
        else if (pf) act = pend;
        pf = 0;
      end else if (load) begin
        pend = cur;
        pf = 1;
      end
      n = (n + 1) % 128;
    end
  always @(negedge clk) begin
    check("anode", anode_n, exp_out[15:8]);
    check("cathode", cathode_n, exp_out[7:0]);
    check("frame_done", frame_done, n == 127);
  end
  task automatic run(int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic do_load(logic [31:0] d, logic [7:0] dp, logic [7:0] en, logic lz);
    digits_in = d;
    dp_in = dp;
    digit_en = en;
    lz_suppress = lz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    digits_in = $urandom;
    dp_in = 8'($urandom);
    digit_en = 8'($urandom);
    lz_suppress = 1'($urandom);
  endtask
  task automatic wait_boundary();
    bit hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (n == 127) hit = 1;
      else @(negedge clk);
    end
    check("boundary_wait", hit, 1);
  endtask
  initial begin
    run(3);
    rst_n = 1'b1;
    do_load(32'h76543210, 8'h00, 8'hFF, 1'b0);
    run(300);
    do_load(32'h0000ABCD, 8'h04, 8'hFF, 1'b0);
    run(300);
    do_load(32'h00000105, 8'h00, 8'hFF, 1'b1);
    run(300);
    do_load(32'h00000000, 8'h00, 8'hFF, 1'b1);
    run(300);
    do_load(32'h11111111, 8'h00, 8'hFF, 1'b0);
    run(40);
    do_load(32'h22222222, 8'h00, 8'hFF, 1'b0);
    run(300);
    wait_boundary();
    do_load(32'h33333333, 8'hFF, 8'hFF, 1'b0);
    run(300);
    do_load(32'h89ABCDEF, 8'h55, 8'h0F, 1'b0);
    run(300);
    repeat (4000) begin
      load = $urandom_range(0, 49) == 0;
      digits_in = $urandom;
      if ($urandom_range(0, 1) == 1) digits_in = digits_in >> (4 * $urandom_range(0, 7));
      dp_in = 8'($urandom);
      digit_en = 8'($urandom);
      lz_suppress = 1'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
    do_load(32'h88888888, 8'hFF, 8'hFF, 1'b0);
    wait_boundary();
    run(22);
    #2 rst_n = 1'b0;
    #1;
    check("rst_anode", anode_n, 8'hFF);
    check("rst_cathode", cathode_n, 8'hFF);
    check("rst_frame_done", frame_done, 0);
    run(3);
    rst_n = 1'b1;
    run(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
